// File: rtl/itch_msg_framer.sv
// ----------------------------------------------------------------------------
// itch_msg_framer
//   Splits the MoldUDP64 message block of a packet into individual ITCH
//   messages. Each message's 2-byte big-endian length prefix is stripped and
//   its body bytes are emitted with start/end flags, type, declared length and
//   per-message sequence number. All outputs are registered (1-cycle latency).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_byte  one payload byte per cycle, no backpressure
//   in_start          first byte of the message block (first length byte)
//   in_last           last byte of the packet
//   in_msg_count      MoldUDP64 message count, sampled on in_start
//   in_seq_num        MoldUDP64 sequence number, sampled on in_start
//   out_valid/out_byte  message body byte
//   out_sop/out_eop     first / last body byte of a message
//   out_type/out_len/out_seq  per-message fields, updated on out_sop
//   out_trunc         packet ended before the message was complete (with eop)
//   out_err           one-cycle framing error pulse
//   pkt_done          one-cycle pulse after the in_last byte was consumed
// ----------------------------------------------------------------------------
module itch_msg_framer #(
    parameter int unsigned MAX_MSG_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_start,
    input  logic        in_last,
    input  logic [15:0] in_msg_count,
    input  logic [63:0] in_seq_num,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  out_type,
    output logic [15:0] out_len,
    output logic [63:0] out_seq,
    output logic        out_trunc,
    output logic        out_err,
    output logic        pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_BODY, S_DRAIN
    } state_e;

    localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_LEN);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [63:0] seq_q,   seq_d;
    logic [15:0] len_q,   len_d;
    logic [15:0] rem_q,   rem_d;

    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_byte_q,  out_byte_d;
    logic        out_sop_q,   out_sop_d;
    logic        out_eop_q,   out_eop_d;
    logic [7:0]  out_type_q,  out_type_d;
    logic [15:0] out_len_q,   out_len_d;
    logic [63:0] out_seq_q,   out_seq_d;
    logic        out_trunc_q, out_trunc_d;
    logic        out_err_q,   out_err_d;
    logic        pkt_done_q,  pkt_done_d;

    // Shared byte decode. An in_start byte restarts the block no matter where
    // the FSM is, so the byte is interpreted in the state it would have from
    // IDLE, with the freshly sampled count and sequence number.
    logic        start_w, last_w, consume_w, heartbeat_w;
    logic        body_first, body_end;
    state_e      cur_st;
    logic [15:0] cur_count;
    logic [63:0] cur_seq;
    logic [15:0] len_full;

    assign start_w     = in_valid && in_start;
    assign last_w      = in_valid && in_last;
    assign consume_w   = in_valid && (in_start || (state_q != S_IDLE));
    assign heartbeat_w = (in_msg_count == 16'h0000) || (in_msg_count == 16'hFFFF);
    assign cur_st      = start_w ? (heartbeat_w ? S_DRAIN : S_LEN_HI) : state_q;
    assign cur_count   = start_w ? in_msg_count : count_q;
    assign cur_seq     = start_w ? in_seq_num : seq_q;
    assign len_full    = {len_q[15:8], in_byte};
    // remaining starts at len and only decreases, so equality marks byte 0.
    assign body_first  = (rem_q == len_q);
    assign body_end    = (rem_q == 16'd1);

    // State register and all datapath / output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            seq_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_type_q  <= '0;
            out_len_q   <= '0;
            out_seq_q   <= '0;
            out_trunc_q <= 1'b0;
            out_err_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_type_q  <= out_type_d;
            out_len_q   <= out_len_d;
            out_seq_q   <= out_seq_d;
            out_trunc_q <= out_trunc_d;
            out_err_q   <= out_err_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (latch).
        state_d = state_q;
        count_d = count_q;
        seq_d   = seq_q;
        len_d   = len_q;
        rem_d   = rem_q;
        if (consume_w) begin
            count_d = cur_count;
            seq_d   = cur_seq;
            case (cur_st)
                S_LEN_HI: begin
                    len_d   = {in_byte, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        // Empty message still consumes a count and a sequence number.
                        count_d = cur_count - 16'd1;
                        seq_d   = cur_seq + 64'd1;
                        state_d = (cur_count == 16'd1) ? S_DRAIN : S_LEN_HI;
                    end else if (len_full > MAX_LEN) begin
                        state_d = S_DRAIN;
                    end else begin
                        rem_d   = len_full;
                        state_d = S_BODY;
                    end
                end
                S_BODY: begin
                    rem_d   = rem_q - 16'd1;
                    state_d = S_BODY;
                    if (body_end) begin
                        count_d = cur_count - 16'd1;
                        seq_d   = cur_seq + 64'd1;
                        state_d = (cur_count == 16'd1) ? S_DRAIN : S_LEN_HI;
                    end
                end
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_IDLE;
            endcase
            // End of packet overrides whatever the byte would otherwise do.
            if (last_w) begin
                state_d = S_IDLE;
            end
        end
    end

    // Output decode (registered on the next edge).
    always_comb begin
        out_valid_d = 1'b0;
        out_byte_d  = out_byte_q;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_type_d  = out_type_q;
        out_len_d   = out_len_q;
        out_seq_d   = out_seq_q;
        out_trunc_d = 1'b0;
        out_err_d   = 1'b0;
        pkt_done_d  = 1'b0;
        if (consume_w) begin
            // Resync while a body is open abandons it without an eop.
            if (start_w && (state_q == S_BODY)) begin
                out_err_d = 1'b1;
            end
            case (cur_st)
                S_LEN_HI: out_err_d = out_err_d | last_w;
                S_LEN_LO: out_err_d = out_err_d | last_w | (len_full > MAX_LEN);
                S_BODY: begin
                    out_valid_d = 1'b1;
                    out_byte_d  = in_byte;
                    out_sop_d   = body_first;
                    out_eop_d   = body_end | last_w;
                    out_trunc_d = last_w & ~body_end;
                    out_err_d   = last_w & ~body_end;
                    if (body_first) begin
                        out_type_d = in_byte;
                        out_len_d  = len_q;
                        out_seq_d  = seq_q;
                    end
                end
                default: ;
            endcase
            pkt_done_d = last_w;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_type  = out_type_q;
    assign out_len   = out_len_q;
    assign out_seq   = out_seq_q;
    assign out_trunc = out_trunc_q;
    assign out_err   = out_err_q;
    assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_itch_msg_framer.sv
// ----------------------------------------------------------------------------
// tb_itch_msg_framer
//   Directed bench for itch_msg_framer. Each block of bytes is run through a
//   packet-level model (a pointer walk over length-prefixed messages) that
//   yields the expected output for every input byte; a compare process checks
//   the DUT against it every cycle. Literal expectations pin the model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_itch_msg_framer;

    localparam int MAX_LEN = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_start;
    logic        in_last;
    logic [15:0] in_msg_count;
    logic [63:0] in_seq_num;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_type;
    logic [15:0] out_len;
    logic [63:0] out_seq;
    logic        out_trunc;
    logic        out_err;
    logic        pkt_done;

    always #5 clk = ~clk;

    itch_msg_framer #(.MAX_MSG_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_start     (in_start),
        .in_last      (in_last),
        .in_msg_count (in_msg_count),
        .in_seq_num   (in_seq_num),
        .out_valid    (out_valid),
        .out_byte     (out_byte),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_type     (out_type),
        .out_len      (out_len),
        .out_seq      (out_seq),
        .out_trunc    (out_trunc),
        .out_err      (out_err),
        .pkt_done     (pkt_done)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  b;
        logic        sop;
        logic        eop;
        logic        trunc;
        logic        err;
        logic        done;
        logic [7:0]  typ;
        logic [15:0] len;
        logic [63:0] seq;
    } ev_t;

    // Model output: one expected event per input byte of the current block.
    ev_t         ev [512];
    bit          model_open;
    bit          pend_open;
    logic [7:0]  pkt [$];

    // One-cycle expectation pipeline plus the held per-message fields.
    ev_t         exp_next;
    ev_t         exp_cur;
    logic [7:0]  h_type;
    logic [15:0] h_len;
    logic [63:0] h_seq;
    bit          chk_en;

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_sop = 0, n_eop = 0, n_trunc = 0, n_err = 0, n_done = 0;
    int b_valid, b_sop, b_eop, b_trunc, b_err, b_done;
    logic [63:0] sop_seq [$];
    logic [7:0]  sop_type [$];

    always @(posedge clk) begin
        if (reset) begin
            exp_cur <= '0;
            h_type  <= '0;
            h_len   <= '0;
            h_seq   <= '0;
        end else begin
            exp_cur <= exp_next;
            if (exp_next.sop) begin
                h_type <= exp_next.typ;
                h_len  <= exp_next.len;
                h_seq  <= exp_next.seq;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Walk the block message by message: 2-byte length, then body.
    task automatic build_model(input logic [15:0] cnt, input logic [63:0] seq, input bit last);
        int          n;
        int          i;
        int          c;
        int          len;
        bit          stop;
        logic [63:0] s;
        n = pkt.size();
        i = 0;
        c = int'(cnt);
        s = seq;
        stop = 1'b0;
        model_open = 1'b0;
        for (int k = 0; k < n; k++) ev[k] = '0;
        if (cnt != 16'h0000 && cnt != 16'hFFFF) begin
            while (c > 0 && !stop) begin
                if (i >= n) begin
                    stop = 1'b1;
                end else if (i == n - 1) begin
                    if (last) ev[i].err = 1'b1;
                    stop = 1'b1;
                end else begin
                    len = int'({pkt[i], pkt[i+1]});
                    if (last && (i + 1 == n - 1)) begin
                        ev[i+1].err = 1'b1;
                        stop = 1'b1;
                    end else begin
                        i += 2;
                        if (len == 0) begin
                            c--;
                            s++;
                        end else if (len > MAX_LEN) begin
                            ev[i-1].err = 1'b1;
                            stop = 1'b1;
                        end else begin
                            for (int k = 0; k < len && !stop; k++) begin
                                if (i + k >= n) begin
                                    model_open = 1'b1;
                                    stop = 1'b1;
                                end else begin
                                    ev[i+k].valid = 1'b1;
                                    ev[i+k].b     = pkt[i+k];
                                    ev[i+k].sop   = (k == 0);
                                    ev[i+k].eop   = (k == len - 1);
                                    if (k == 0) begin
                                        ev[i+k].typ = pkt[i];
                                        ev[i+k].len = 16'(len);
                                        ev[i+k].seq = s;
                                    end
                                    if (last && (i + k == n - 1) && (k != len - 1)) begin
                                        ev[i+k].eop   = 1'b1;
                                        ev[i+k].trunc = 1'b1;
                                        ev[i+k].err   = 1'b1;
                                        stop = 1'b1;
                                    end
                                end
                            end
                            i += len;
                            c--;
                            s++;
                        end
                    end
                end
            end
        end
        if (last) ev[n-1].done = 1'b1;
    endtask

    // Drive the bytes in pkt back to back; optional idle cycle after byte gap_after.
    task automatic send_block(input logic [15:0] cnt, input logic [63:0] seq, input bit last,
                              input int gap_after);
        build_model(cnt, seq, last);
        for (int k = 0; k < pkt.size(); k++) begin
            @(posedge clk); #1;
            in_valid     = 1'b1;
            in_byte      = pkt[k];
            in_start     = (k == 0);
            in_last      = last && (k == pkt.size() - 1);
            in_msg_count = (k == 0) ? cnt : 16'h5A5A;
            in_seq_num   = (k == 0) ? seq : 64'hDEAD_BEEF_0BAD_F00D;
            exp_next     = ev[k];
            if (k == 0 && pend_open) exp_next.err = 1'b1;
            if (k == gap_after) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_start = 1'b0;
                in_last  = 1'b0;
                in_byte  = 8'hEE;
                exp_next = '0;
            end
        end
        pend_open = model_open;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_start = 1'b0;
            in_last  = 1'b0;
            exp_next = '0;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_last  = 1'b0;
        exp_next = '0;
        for (int k = 1; k < n; k++) @(posedge clk);
        @(posedge clk); #1;
        reset     = 1'b0;
        pend_open = 1'b0;
    endtask

    task automatic compare_cycle();
        check("flags{valid,sop,eop,trunc,err,done}",
              64'({out_valid, out_sop, out_eop, out_trunc, out_err, pkt_done}),
              64'({exp_cur.valid, exp_cur.sop, exp_cur.eop, exp_cur.trunc, exp_cur.err, exp_cur.done}));
        if (exp_cur.valid) check("out_byte", 64'(out_byte), 64'(exp_cur.b));
        check("out_type", 64'(out_type), 64'(h_type));
        check("out_len",  64'(out_len),  64'(h_len));
        check("out_seq",  out_seq, h_seq);
        if (out_valid) n_valid++;
        if (out_sop) begin
            n_sop++;
            sop_seq.push_back(out_seq);
            sop_type.push_back(out_type);
        end
        if (out_eop)   n_eop++;
        if (out_trunc) n_trunc++;
        if (out_err)   n_err++;
        if (pkt_done)  n_done++;
    endtask

    task automatic snap();
        b_valid = n_valid; b_sop = n_sop; b_eop = n_eop;
        b_trunc = n_trunc; b_err = n_err; b_done = n_done;
    endtask

    task automatic check_counts(input string name, input int v, input int e, input int er, input int d);
        check({name, " bytes"},    64'(n_valid - b_valid), 64'(v));
        check({name, " eops"},     64'(n_eop - b_eop),     64'(e));
        check({name, " errs"},     64'(n_err - b_err),     64'(er));
        check({name, " pkt_done"}, 64'(n_done - b_done),   64'(d));
    endtask

    task automatic check_sop(input string name, input int idx, input logic [7:0] t, input logic [63:0] s);
        if (sop_seq.size() > idx) begin
            check({name, " type"}, 64'(sop_type[idx]), 64'(t));
            check({name, " seq"},  sop_seq[idx], s);
        end else begin
            check({name, " sop missing"}, 64'(sop_seq.size()), 64'(idx + 1));
        end
    endtask

    initial begin : main
        reset = 1'b1; in_valid = 1'b0; in_byte = '0; in_start = 1'b0; in_last = 1'b0;
        in_msg_count = '0; in_seq_num = '0; exp_next = '0; chk_en = 1'b0; pend_open = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) compare_cycle();
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset out_seq",  out_seq, 64'd0);
        check("reset out_type", 64'(out_type), 64'd0);

        // Two messages, an idle gap inside the first, then a heartbeat back to back.
        snap();
        pkt = '{8'h00, 8'h03, 8'h41, 8'h11, 8'h22, 8'h00, 8'h02, 8'h45, 8'h33};
        send_block(16'd2, 64'd100, 1'b1, 3);
        pkt = '{8'h00, 8'h05, 8'h41, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_block(16'h0000, 64'd7, 1'b1, -1);
        idle(2);
        check_counts("two_msg+hb0", 5, 2, 0, 2);
        check_sop("two_msg m0", b_sop, 8'h41, 64'd100);
        check_sop("two_msg m1", b_sop + 1, 8'h45, 64'd101);
        check("two_msg len held", 64'(out_len), 64'd2);

        // End-of-session count.
        snap();
        pkt = '{8'h00, 8'h01, 8'h41, 8'h00, 8'h01, 8'h42, 8'h77, 8'h88};
        send_block(16'hFFFF, 64'd9, 1'b1, -1);
        idle(2);
        check_counts("hb_ffff", 0, 0, 0, 1);

        // Truncation: 16-byte message cut after 5 body bytes.
        snap();
        pkt = '{8'h00, 8'h10, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        send_block(16'd1, 64'd42, 1'b1, -1);
        idle(2);
        check_counts("trunc", 5, 1, 1, 1);
        check("trunc flag count", 64'(n_trunc - b_trunc), 64'd1);

        // Oversize length 65.
        snap();
        pkt = '{8'h00, 8'h41, 8'h46, 8'h01, 8'h02};
        send_block(16'd1, 64'd1, 1'b1, -1);
        idle(2);
        check_counts("oversize", 0, 0, 1, 1);

        // Exactly MAX_MSG_LEN bytes, then trailing bytes drained.
        snap();
        pkt = '{8'h00, 8'h40};
        for (int k = 0; k < 64; k++) pkt.push_back(8'(k + 8'h80));
        pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(8'h99);
        send_block(16'd1, 64'd5000, 1'b1, -1);
        idle(2);
        check_counts("max_len", 64, 1, 0, 1);

        // Zero-length message between two 1-byte messages.
        snap();
        pkt = '{8'h00, 8'h01, 8'h41, 8'h00, 8'h00, 8'h00, 8'h01, 8'h42};
        send_block(16'd3, 64'h1000, 1'b1, -1);
        idle(2);
        check_counts("zero_len", 2, 2, 0, 1);
        check_sop("zero_len m0", b_sop, 8'h41, 64'h1000);
        check_sop("zero_len m2", b_sop + 1, 8'h42, 64'h1002);

        // Sequence number wrap.
        snap();
        pkt = '{8'h00, 8'h01, 8'h58, 8'h00, 8'h01, 8'h59};
        send_block(16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1);
        idle(2);
        check_sop("wrap m0", b_sop, 8'h58, 64'hFFFF_FFFF_FFFF_FFFF);
        check_sop("wrap m1", b_sop + 1, 8'h59, 64'd0);

        // in_start mid-body resynchronises onto the new block.
        snap();
        pkt = '{8'h00, 8'h04, 8'h41, 8'h01};
        send_block(16'd1, 64'd300, 1'b0, -1);
        pkt = '{8'h00, 8'h02, 8'h51, 8'h05};
        send_block(16'd1, 64'd500, 1'b1, -1);
        idle(2);
        check_counts("resync", 4, 1, 1, 1);
        check_sop("resync new", b_sop + 1, 8'h51, 64'd500);

        // in_start and in_last on one byte.
        snap();
        pkt = '{8'h00};
        send_block(16'd1, 64'd1, 1'b1, -1);
        idle(1);
        pkt = '{8'h00};
        send_block(16'h0000, 64'd1, 1'b1, -1);
        idle(2);
        check_counts("start_last", 0, 0, 1, 2);

        // Reset mid-body, then a clean packet.
        pkt = '{8'h00, 8'h05, 8'h61, 8'h62};
        send_block(16'd1, 64'd77, 1'b0, -1);
        do_reset(1);
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid out_seq",   out_seq, 64'd0);
        check("rst mid out_len",   64'(out_len), 64'd0);
        snap();
        pkt = '{8'h00, 8'h01, 8'h70};
        send_block(16'd1, 64'd7, 1'b1, -1);
        idle(2);
        check_counts("post_reset", 1, 1, 0, 1);
        check_sop("post_reset m0", b_sop, 8'h70, 64'd7);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
